// File: rtl/intra4x4_pred_mode_ctrl_pkg.sv
// Shared definitions for the Intra4x4 prediction-mode controller.
// Holds default widths, the DC mode constant, the FSM state type and the
// (x, y) -> luma4x4BlkIdx helper.
package intra4x4_pred_mode_ctrl_pkg;

  localparam int unsigned DefMbXBits = 7;
  localparam int unsigned DefMbYBits = 7;
  localparam int unsigned DefMaxMbX  = 120;

  localparam logic [3:0]  Intra4x4Dc = 4'd2;
  localparam logic [63:0] AllDc      = {16{Intra4x4Dc}};

  typedef enum logic [1:0] {
    StIdle,
    StRdUp,
    StRun,
    StCommit
  } state_e;

  // Block index from 4x4 position inside the MB: idx = {y[1], x[1], y[0], x[0]}.
  function automatic logic [3:0] blk_idx(input logic [1:0] bx, input logic [1:0] by);
    return {by[1], bx[1], by[0], bx[0]};
  endfunction

endpackage

// File: rtl/intra4x4_pred_mode_ctrl_if.sv
// Parser/controller bus for the Intra4x4 prediction-mode controller.
// master: slice-data parser side (drives MB start and block syntax elements).
// slave : controller side (drives handshake, decoded modes and MB status).
interface intra4x4_pred_mode_ctrl_if #(
  parameter int unsigned MbXBits = 7,
  parameter int unsigned MbYBits = 7
);
  logic               mb_start_in;
  logic [MbXBits-1:0] mb_x_in;
  logic [MbYBits-1:0] mb_y_in;
  logic               mb_is_i4x4_in;
  logic               blk_valid_in;
  logic               prev_intra4x4_pred_mode_in;
  logic [2:0]         rem_intra4x4_pred_mode_in;
  logic               blk_ready_out;
  logic               busy_out;
  logic               mode_valid_out;
  logic [3:0]         mode_out;
  logic [3:0]         mode_blk_idx_out;
  logic [63:0]        cur_modes_out;
  logic               mb_done_out;

  modport master (
    output mb_start_in, mb_x_in, mb_y_in, mb_is_i4x4_in, blk_valid_in,
           prev_intra4x4_pred_mode_in, rem_intra4x4_pred_mode_in,
    input  blk_ready_out, busy_out, mode_valid_out, mode_out, mode_blk_idx_out,
           cur_modes_out, mb_done_out
  );

  modport slave (
    input  mb_start_in, mb_x_in, mb_y_in, mb_is_i4x4_in, blk_valid_in,
           prev_intra4x4_pred_mode_in, rem_intra4x4_pred_mode_in,
    output blk_ready_out, busy_out, mode_valid_out, mode_out, mode_blk_idx_out,
           cur_modes_out, mb_done_out
  );
endinterface

// File: rtl/intra4x4_mode_line_buf.sv
// Up-row mode line buffer: one 16-bit entry (bottom-row modes, nibble x) per
// MB column. Single port, synchronous read, contents are not reset.
module intra4x4_mode_line_buf #(
  parameter int unsigned Depth    = 120,
  parameter int unsigned AddrBits = 7
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AddrBits-1:0] addr_i,
  input  logic [15:0]         wdata_i,
  output logic [15:0]         rdata_o
);
  logic [15:0] mem_q [Depth];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/intra4x4_pred_mode_decoding.sv
// Combinational Intra4x4PredMode derivation for one 4x4 block.
// Inputs: MB position, block index, up-MB bottom row, left-MB right column,
// current-MB modes, prev flag and rem. Output: decoded mode 0..8.
module intra4x4_pred_mode_decoding
  import intra4x4_pred_mode_ctrl_pkg::*;
#(
  parameter int unsigned MbXBits = DefMbXBits,
  parameter int unsigned MbYBits = DefMbYBits
) (
  input  logic [MbXBits-1:0] mb_x_i,
  input  logic [MbYBits-1:0] mb_y_i,
  input  logic [3:0]         blk_idx_i,
  input  logic [15:0]        up_modes_i,   // nibble x = up MB bottom row
  input  logic [15:0]        left_modes_i, // nibble y = left MB right column
  input  logic [63:0]        cur_modes_i,
  input  logic               prev_flag_i,
  input  logic [2:0]         rem_mode_i,
  output logic [3:0]         mode_o
);
  logic [1:0] bx, by;
  logic       avail_a, avail_b;
  logic [3:0] mode_a, mode_b, pred, rem_ext;

  assign bx = {blk_idx_i[2], blk_idx_i[0]};
  assign by = {blk_idx_i[3], blk_idx_i[1]};

  always_comb begin
    avail_a = 1'b1;
    mode_a  = Intra4x4Dc;
    if (bx != 2'd0) begin
      mode_a = cur_modes_i[{blk_idx(bx - 2'd1, by), 2'b00} +: 4];
    end else if (mb_x_i == '0) begin
      avail_a = 1'b0;
    end else begin
      mode_a = left_modes_i[{by, 2'b00} +: 4];
    end

    avail_b = 1'b1;
    mode_b  = Intra4x4Dc;
    if (by != 2'd0) begin
      mode_b = cur_modes_i[{blk_idx(bx, by - 2'd1), 2'b00} +: 4];
    end else if (mb_y_i == '0) begin
      avail_b = 1'b0;
    end else begin
      mode_b = up_modes_i[{bx, 2'b00} +: 4];
    end

    pred    = (avail_a && avail_b) ? ((mode_a < mode_b) ? mode_a : mode_b) : Intra4x4Dc;
    rem_ext = {1'b0, rem_mode_i};
    if (prev_flag_i)        mode_o = pred;
    else if (rem_ext < pred) mode_o = rem_ext;
    else                     mode_o = rem_ext + 4'd1;
  end
endmodule

// File: rtl/intra4x4_pred_mode_ctrl.sv
// Intra4x4 prediction-mode sequencer. Accepts prev/rem per 4x4 block in
// luma4x4BlkIdx order, derives each mode from the current MB, the left MB's
// right column and the up MB's bottom row (line buffer), emits decoded modes
// and commits neighbour context at MB end.
// Ports: clk, rst (async, active-high), bus (slave side of the parser bus).
module intra4x4_pred_mode_ctrl
  import intra4x4_pred_mode_ctrl_pkg::*;
#(
  parameter int unsigned MbXBits = DefMbXBits,
  parameter int unsigned MbYBits = DefMbYBits,
  parameter int unsigned MaxMbX  = DefMaxMbX
) (
  input logic                    clk,
  input logic                    rst,
  intra4x4_pred_mode_ctrl_if.slave bus
);
  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [MbXBits-1:0] x_q, x_d;
  logic [MbYBits-1:0] y_q, y_d;
  logic               i4_q, i4_d;
  logic [15:0]        up_q, up_d, left_q, left_d;
  logic [63:0]        cur_q, cur_d;
  logic [3:0]         mode_q, mode_d, idx_q, idx_d;
  logic               mv_q, mv_d, done_q, done_d;

  logic               busy, ready, accept, lb_we;
  logic [MbXBits-1:0] lb_addr;
  logic [15:0]        lb_rdata, lb_wdata;
  logic [3:0]         dec_mode;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.mb_start_in) state_d = StRdUp;
      StRdUp:   state_d = i4_q ? StRun : StCommit;
      StRun:    if (accept && cnt_q == 4'd15) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    busy    = (state_q != StIdle);
    ready   = (state_q == StRun);
    lb_we   = (state_q == StCommit);
    // In IDLE the address follows the input so the read lands as we enter RD_UP.
    lb_addr = (state_q == StIdle) ? bus.mb_x_in : x_q;
  end

  assign accept   = ready & bus.blk_valid_in;
  assign lb_wdata = {cur_q[63:60], cur_q[59:56], cur_q[47:44], cur_q[43:40]};

  // Datapath next state
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    i4_d   = i4_q;
    up_d   = up_q;
    left_d = left_q;
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    idx_d  = idx_q;
    mv_d   = accept;
    done_d = (state_q == StCommit);
    unique case (state_q)
      StIdle: begin
        if (bus.mb_start_in) begin
          x_d  = bus.mb_x_in;
          y_d  = bus.mb_y_in;
          i4_d = bus.mb_is_i4x4_in;
        end
      end
      StRdUp: begin
        up_d  = lb_rdata;
        cnt_d = 4'd0;
        if (!i4_q) cur_d = AllDc;
      end
      StRun: begin
        if (accept) begin
          cur_d[{cnt_q, 2'b00} +: 4] = dec_mode;
          mode_d = dec_mode;
          idx_d  = cnt_q;
          cnt_d  = cnt_q + 4'd1;
        end
      end
      StCommit: left_d = {cur_q[63:60], cur_q[55:52], cur_q[31:28], cur_q[23:20]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      i4_q   <= 1'b0;
      up_q   <= '0;
      left_q <= {4{Intra4x4Dc}};
      cur_q  <= AllDc;
      cnt_q  <= 4'd0;
      mode_q <= 4'd0;
      idx_q  <= 4'd0;
      mv_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      i4_q   <= i4_d;
      up_q   <= up_d;
      left_q <= left_d;
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      idx_q  <= idx_d;
      mv_q   <= mv_d;
      done_q <= done_d;
    end
  end

  intra4x4_pred_mode_decoding #(
    .MbXBits(MbXBits),
    .MbYBits(MbYBits)
  ) u_dec (
    .mb_x_i      (x_q),
    .mb_y_i      (y_q),
    .blk_idx_i   (cnt_q),
    .up_modes_i  (up_q),
    .left_modes_i(left_q),
    .cur_modes_i (cur_q),
    .prev_flag_i (bus.prev_intra4x4_pred_mode_in),
    .rem_mode_i  (bus.rem_intra4x4_pred_mode_in),
    .mode_o      (dec_mode)
  );

  intra4x4_mode_line_buf #(
    .Depth   (MaxMbX),
    .AddrBits(MbXBits)
  ) u_line_buf (
    .clk_i  (clk),
    .we_i   (lb_we),
    .addr_i (lb_addr),
    .wdata_i(lb_wdata),
    .rdata_o(lb_rdata)
  );

  assign bus.busy_out         = busy;
  assign bus.blk_ready_out    = ready;
  assign bus.mode_valid_out   = mv_q;
  assign bus.mode_out         = mode_q;
  assign bus.mode_blk_idx_out = idx_q;
  assign bus.cur_modes_out    = cur_q;
  assign bus.mb_done_out      = done_q;
endmodule
